// File: rtl/hilo_pkg.sv
// Shared types for the speculative HI/LO buffer: write-enable encoding and the queue entry.
package hilo_pkg;

    typedef logic [1:0] hilo_we_t;

    localparam hilo_we_t HILO_WE_HI   = 2'b10;
    localparam hilo_we_t HILO_WE_LO   = 2'b01;
    localparam hilo_we_t HILO_WE_BOTH = 2'b11;

    localparam int unsigned HILO_DW = 32;

    // Entry at the default width; the top builds the same layout at its own DW.
    typedef struct packed {
        hilo_we_t           we;
        logic [HILO_DW-1:0] hi;
        logic [HILO_DW-1:0] lo;
    } hilo_entry_t;

    function automatic logic we_has_hi(hilo_we_t we);
        return we[1];
    endfunction

    function automatic logic we_has_lo(hilo_we_t we);
        return we[0];
    endfunction

endpackage

// File: rtl/hilo_spec_buf_if.sv
// MEM/WB/ID-facing signal bundle of the speculative HI/LO buffer.
interface hilo_spec_buf_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 2
);
    import hilo_pkg::*;

    logic          spec_valid_i;
    hilo_we_t      spec_we_i;
    logic [DW-1:0] spec_hi_i;
    logic [DW-1:0] spec_lo_i;
    logic          spec_ready_o;
    logic          commit_i;
    logic          flush_i;
    logic [DW-1:0] rd_hi_o;
    logic [DW-1:0] rd_lo_o;
    logic [DW-1:0] arch_hi_o;
    logic [DW-1:0] arch_lo_o;
    logic [CW-1:0] pend_cnt_o;
    logic          err_o;

    modport master (
        output spec_valid_i, spec_we_i, spec_hi_i, spec_lo_i, commit_i, flush_i,
        input  spec_ready_o, rd_hi_o, rd_lo_o, arch_hi_o, arch_lo_o, pend_cnt_o, err_o
    );

    modport slave (
        input  spec_valid_i, spec_we_i, spec_hi_i, spec_lo_i, commit_i, flush_i,
        output spec_ready_o, rd_hi_o, rd_lo_o, arch_hi_o, arch_lo_o, pend_cnt_o, err_o
    );

endinterface

// File: rtl/hilo_fwd_sel.sv
// Youngest-match search over the pending queue for one half (HI or LO); falls back to arch.
module hilo_fwd_sel #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]         we,
    input  logic [DEPTH-1:0][DW-1:0] data,
    input  logic [PW-1:0]            head,
    input  logic [CW-1:0]            count,
    input  logic [DW-1:0]            arch,
    output logic [DW-1:0]            sel
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last hit (the youngest) wins.
    always_comb begin
        sel = arch;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && we[idx]) begin
                sel = data[idx];
            end
        end
    end

endmodule

// File: rtl/hilo_spec_buf.sv
// Architectural HI/LO with an in-order queue of speculative writes: push from MEM,
// retire on WB commit, drop on flush, and forward the youngest pending value to ID.
module hilo_spec_buf
    import hilo_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input logic           clk_i,
    input logic           rst_i,
    hilo_spec_buf_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        hilo_we_t      we;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [DW-1:0] arch_hi_q, arch_lo_q;
    logic          err_q;

    logic full, push_acc, commit_acc, push_err, commit_err;
    entry_t head_entry;

    assign full       = (count_q == CW'(DEPTH));
    assign push_acc   = bus.spec_valid_i && !full && !bus.flush_i;
    assign commit_acc = bus.commit_i && (count_q != '0);
    // A push collides with flush silently; only a genuine overflow is an error.
    assign push_err   = bus.spec_valid_i && full && !bus.flush_i;
    assign commit_err = bus.commit_i && (count_q == '0);
    assign head_entry = mem_q[head_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            arch_hi_q <= '0;
            arch_lo_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (commit_acc) begin
                if (we_has_hi(head_entry.we)) arch_hi_q <= head_entry.hi;
                if (we_has_lo(head_entry.we)) arch_lo_q <= head_entry.lo;
            end
            if (bus.flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_acc)   tail_q <= tail_q + 1'b1;
                if (commit_acc) head_q <= head_q + 1'b1;
                count_q <= count_q + CW'(push_acc) - CW'(commit_acc);
            end
            if (push_err || commit_err) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[tail_q] <= '{we: bus.spec_we_i, hi: bus.spec_hi_i, lo: bus.spec_lo_i};
        end
    end

    logic [DEPTH-1:0]         we_hi, we_lo;
    logic [DEPTH-1:0][DW-1:0] data_hi, data_lo;

    always_comb begin
        we_hi   = '0;
        we_lo   = '0;
        data_hi = '0;
        data_lo = '0;
        for (int k = 0; k < DEPTH; k++) begin
            we_hi[k]   = we_has_hi(mem_q[k].we);
            we_lo[k]   = we_has_lo(mem_q[k].we);
            data_hi[k] = mem_q[k].hi;
            data_lo[k] = mem_q[k].lo;
        end
    end

    hilo_fwd_sel #(.DW(DW), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd_hi (
        .we    (we_hi),
        .data  (data_hi),
        .head  (head_q),
        .count (count_q),
        .arch  (arch_hi_q),
        .sel   (bus.rd_hi_o)
    );

    hilo_fwd_sel #(.DW(DW), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd_lo (
        .we    (we_lo),
        .data  (data_lo),
        .head  (head_q),
        .count (count_q),
        .arch  (arch_lo_q),
        .sel   (bus.rd_lo_o)
    );

    assign bus.spec_ready_o = !full;
    assign bus.arch_hi_o    = arch_hi_q;
    assign bus.arch_lo_o    = arch_lo_q;
    assign bus.pend_cnt_o   = count_q;
    assign bus.err_o        = err_q;

endmodule
